// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin sharing of one dual-ported BRAM between two requesters.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (rq0 wins ties on both channels).
module bram_arbiter #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rq0_valid,
    input  logic               i_rq0_we,
    input  logic [ADDR_SZ-1:0] i_rq0_addr,
    input  logic [DATA_SZ-1:0] i_rq0_wdata,
    output logic               o_rq0_ready,
    output logic               o_rq0_rvalid,
    output logic [DATA_SZ-1:0] o_rq0_rdata,
    input  logic               i_rq1_valid,
    input  logic               i_rq1_we,
    input  logic [ADDR_SZ-1:0] i_rq1_addr,
    input  logic [DATA_SZ-1:0] i_rq1_wdata,
    output logic               o_rq1_ready,
    output logic               o_rq1_rvalid,
    output logic [DATA_SZ-1:0] o_rq1_rdata,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata
);
    logic w_wc0, w_wc1, w_rc0, w_rc1;
    logic w_wg0, w_wg1, w_rg0, w_rg1;
    logic w_rsel1, w_haz, w_wpri1, w_rpri1;
    logic r_rvalid0, r_rvalid1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign w_wpri1 = 1'b0;
    assign w_rpri1 = 1'b0;
`else
    logic r_wr_ptr, r_rd_ptr;
    assign w_wpri1 = r_wr_ptr;
    assign w_rpri1 = r_rd_ptr;
    // granting rq k hands the tie-break to the other requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (o_wr_en) r_wr_ptr <= w_wg0;
            if (o_rd_en) r_rd_ptr <= w_rg0;
        end
    end
`endif

    assign w_wc0 = i_rst_n & i_rq0_valid & i_rq0_we;
    assign w_wc1 = i_rst_n & i_rq1_valid & i_rq1_we;
    assign w_rc0 = i_rst_n & i_rq0_valid & ~i_rq0_we;
    assign w_rc1 = i_rst_n & i_rq1_valid & ~i_rq1_we;

    assign w_wg1   = w_wc1 & (~w_wc0 | w_wpri1);
    assign w_wg0   = w_wc0 & ~w_wg1;
    assign w_rsel1 = w_rc1 & (~w_rc0 | w_rpri1);
    // a read colliding with the granted write waits so it returns the new data
    assign w_haz   = o_wr_en & (w_rc0 | w_rc1) & (o_raddr == o_waddr);
    assign w_rg1   = w_rsel1 & ~w_haz;
    assign w_rg0   = w_rc0 & ~w_rsel1 & ~w_haz;

    assign o_wr_en = w_wg0 | w_wg1;
    assign o_waddr = w_wg1 ? i_rq1_addr : i_rq0_addr;
    assign o_wdata = w_wg1 ? i_rq1_wdata : i_rq0_wdata;
    assign o_rd_en = w_rg0 | w_rg1;
    assign o_raddr = w_rsel1 ? i_rq1_addr : i_rq0_addr;

    assign o_rq0_ready = w_wg0 | w_rg0;
    assign o_rq1_ready = w_wg1 | w_rg1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_rg0;
            r_rvalid1 <= w_rg1;
        end
    end

    assign o_rq0_rvalid = r_rvalid0;
    assign o_rq1_rvalid = r_rvalid1;
    assign o_rq0_rdata  = i_rdata;
    assign o_rq1_rdata  = i_rdata;
endmodule
